// File: rtl/inv_key_pkg.sv
// Shared constants, types and the round-constant lookup for the inverse round-key server.
package inv_key_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  // NR as a 4-bit round index, for comparisons against cnt/idx
  localparam logic [3:0] NR_IDX = 4'(NR);

  typedef logic [KEY_W-1:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    SERVE  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_round_step.sv
// One forward key-schedule round (rotate + rcon, no SubWord), purely combinational.
// Zero latency; no handshake, the caller decides when the result is stored.
module key_round_step
  import inv_key_pkg::*;
(
  input  logic [KEY_W-1:0] prev_key,
  input  logic [3:0]       round,
  output logic [KEY_W-1:0] next_key
);

  logic [31:0] p0, p1, p2, p3;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] g;

  assign p0 = prev_key[31:0];
  assign p1 = prev_key[63:32];
  assign p2 = prev_key[95:64];
  assign p3 = prev_key[127:96];

  assign g  = {p0[23:0], p0[31:24]} ^ {rcon(round), 24'h0};

  assign w0 = p0 ^ g;
  assign w1 = p1 ^ w0;
  assign w2 = p2 ^ w1;
  assign w3 = p3 ^ w2;

  assign next_key = {w3, w2, w1, w0};

endmodule

// File: rtl/inv_round_key_server.sv
// Expands a cipher key one round per cycle into an 11-entry store, then streams rounds NR..0.
// First round key 11 cycles after key accept; rk_out/rk_round held while rk_ready is low.
module inv_round_key_server
  import inv_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             replay,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_round,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last,
  output logic             busy
);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] idx, idx_nxt;
  logic [3:0] cnt_prev;
  logic       key_acc;

  round_key_t store [0:NR];
  round_key_t step_out;

  assign key_acc  = key_valid && key_ready;
  assign cnt_prev = cnt - 4'd1;

  key_round_step u_step (
    .prev_key (store[cnt_prev]),
    .round    (cnt),
    .next_key (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Store contents are don't-care after reset, so no reset branch here
  always_ff @(posedge clk) begin
    if (key_acc) begin
      store[0] <= key_in;
    end else if (state == EXPAND) begin
      store[cnt] <= step_out;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (key_valid) begin
          state_nxt = EXPAND;
          cnt_nxt   = 4'd1;
        end
      end
      EXPAND: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == NR_IDX) begin
          state_nxt = SERVE;
          cnt_nxt   = 4'd0;
          idx_nxt   = NR_IDX;
        end
      end
      SERVE: begin
        // A new key aborts the stream; replay beats a same-cycle handshake
        if (key_valid) begin
          state_nxt = EXPAND;
          cnt_nxt   = 4'd1;
        end else if (replay) begin
          idx_nxt = NR_IDX;
        end else if (rk_ready) begin
          if (idx == 4'd0) begin
            state_nxt = HOLD;
          end else begin
            idx_nxt = idx - 4'd1;
          end
        end
      end
      HOLD: begin
        if (key_valid) begin
          state_nxt = EXPAND;
          cnt_nxt   = 4'd1;
        end else if (replay) begin
          state_nxt = SERVE;
          idx_nxt   = NR_IDX;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    rk_out    = '0;
    rk_round  = 4'd0;
    rk_last   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: key_ready = 1'b1;
      EXPAND: busy = 1'b1;
      SERVE: begin
        key_ready = 1'b1;
        rk_valid  = 1'b1;
        rk_out    = store[idx];
        rk_round  = idx;
        rk_last   = (idx == 4'd0);
      end
      HOLD: key_ready = 1'b1;
      default: key_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_inv_round_key_server.sv
// Randomized bench for inv_round_key_server against a word-level key-schedule model.
module tb_inv_round_key_server;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         replay;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] obs_rk [0:10];
  logic [7:0]   rcon_tab [1:10];

  inv_round_key_server dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .replay    (replay),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: flat word recurrence w[4r+j], words of round r derived from round r-1
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[j] = k[32*j +: 32];
    for (int r = 1; r <= 10; r++) begin
      t = w[4*r-4];
      t = {t[23:0], t[31:24]} ^ {rcon_tab[r], 24'h0};
      w[4*r] = w[4*r-4] ^ t;
      for (int j = 1; j < 4; j++) w[4*r+j] = w[4*r-4+j] ^ w[4*r+j-1];
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic send_key(input logic [127:0] k);
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_key_ready: got %b expected 1", key_ready);
    end
    key_in = k; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // From the negedge after accept: count cycles until rk_valid and busy cycles seen
  task automatic wait_stream();
    int n, nb;
    n = 0; nb = 0;
    while (!rk_valid && n < 40) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL latency: got %0d cycles after accept cycle, expected 10", n);
    end
    checks++;
    if (nb != 10) begin
      failures++;
      $display("FAIL busy_cycles: got %0d expected 10", nb);
    end
  endtask

  // pattern 0: ready always, 1: 1,0,0,1 repeating, 2: random. replay_at<0 disables replay.
  task automatic drain(input int pattern, input int replay_at);
    int er, cyc, ph;
    bit replayed;
    er = 10; cyc = 0; ph = 0; replayed = 0;
    while (er >= 0 && cyc < 300) begin
      replay = 1'b0;
      checks++;
      if (rk_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_valid: got %b expected 1 at expected round %0d", rk_valid, er);
        break;
      end
      checks++;
      if (rk_round !== 4'(er) || rk_out !== exp_rk[er] || rk_last !== (er == 0) || busy !== 1'b0) begin
        failures++;
        $display("FAIL drain_key: got round %0d key %h last %b busy %b expected round %0d key %h last %b busy 0",
                 rk_round, rk_out, rk_last, busy, er, exp_rk[er], (er == 0));
      end
      obs_rk[er] = rk_out;
      case (pattern)
        1:       rk_ready = (ph % 4 == 0) || (ph % 4 == 3);
        2:       rk_ready = 1'($urandom_range(0, 1));
        default: rk_ready = 1'b1;
      endcase
      ph++;
      if (replay_at >= 0 && !replayed && er == replay_at) begin
        replay = 1'b1; rk_ready = 1'b1; replayed = 1'b1; er = 10;
      end else if (rk_ready) begin
        er--;
      end
      @(negedge clk);
      cyc++;
    end
    replay = 1'b0; rk_ready = 1'b1;
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || cyc >= 300) begin
      failures++;
      $display("FAIL hold_state: got valid %b key_ready %b busy %b cycles %0d expected 0 1 0 <300",
               rk_valid, key_ready, busy, cyc);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_last !== 1'b0 || busy !== 1'b0 ||
        rk_out !== 128'h0 || rk_round !== 4'h0) begin
      failures++;
      $display("FAIL reset: got ready %b valid %b last %b busy %b out %h round %0d expected 1 0 0 0 0 0",
               key_ready, rk_valid, rk_last, busy, rk_out, rk_round);
    end
  endtask

  task automatic test_zero_key();
    model_expand(128'h0);
    send_key(128'h0);
    wait_stream();
    drain(0, -1);
    checks++;
    if (obs_rk[2] !== 128'h02000001_03000001_02000001_03000001) begin
      failures++;
      $display("FAIL zero_round2: got %h expected 02000001030000010200000103000001", obs_rk[2]);
    end
    checks++;
    if (obs_rk[1] !== 128'h01000000_01000000_01000000_01000000) begin
      failures++;
      $display("FAIL zero_round1: got %h expected 01000000010000000100000001000000", obs_rk[1]);
    end
    checks++;
    if (obs_rk[0] !== 128'h0) begin
      failures++;
      $display("FAIL zero_round0: got %h expected 0", obs_rk[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] k;
    k = rand_key();
    model_expand(k);
    send_key(k);
    wait_stream();
    drain(1, -1);
  endtask

  task automatic test_replay_hold();
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd10) begin
      failures++;
      $display("FAIL replay_hold: got valid %b round %0d expected 1 10", rk_valid, rk_round);
    end
    drain(0, -1);
  endtask

  task automatic test_replay_serve();
    logic [127:0] k;
    k = rand_key();
    model_expand(k);
    send_key(k);
    wait_stream();
    drain(0, 4);
  endtask

  task automatic test_key_abort();
    logic [127:0] k1, k2;
    int er;
    k1 = rand_key(); k2 = rand_key();
    model_expand(k1);
    send_key(k1);
    wait_stream();
    er = 10;
    while (er > 6) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(er) || rk_out !== exp_rk[er]) begin
        failures++;
        $display("FAIL abort_prefix: got valid %b round %0d expected 1 %0d", rk_valid, rk_round, er);
      end
      rk_ready = 1'b1;
      @(negedge clk);
      er--;
    end
    checks++;
    if (rk_round !== 4'd6) begin
      failures++;
      $display("FAIL abort_at6: got round %0d expected 6", rk_round);
    end
    key_in = k2; key_valid = 1'b1; replay = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; replay = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_next: got valid %b busy %b expected 0 1", rk_valid, busy);
    end
    model_expand(k2);
    wait_stream();
    drain(0, -1);
  endtask

  task automatic test_rst_mid_expand();
    logic [127:0] k;
    k = rand_key();
    send_key(k);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || key_ready !== 1'b1 || rk_round !== 4'd0 || rk_out !== 128'h0) begin
      failures++;
      $display("FAIL rst_mid_expand: got busy %b valid %b ready %b round %0d expected 0 0 1 0",
               busy, rk_valid, key_ready, rk_round);
    end
    k = rand_key();
    model_expand(k);
    send_key(k);
    wait_stream();
    drain(0, -1);
  endtask

  task automatic test_random();
    logic [127:0] k;
    for (int n = 0; n < 4; n++) begin
      k = rand_key();
      model_expand(k);
      send_key(k);
      wait_stream();
      drain(2, -1);
    end
  endtask

  initial begin
    rcon_tab[1] = 8'h01; rcon_tab[2] = 8'h02; rcon_tab[3] = 8'h04; rcon_tab[4] = 8'h08;
    rcon_tab[5] = 8'h10; rcon_tab[6] = 8'h20; rcon_tab[7] = 8'h40; rcon_tab[8] = 8'h80;
    rcon_tab[9] = 8'h1b; rcon_tab[10] = 8'h36;
    rst = 1'b1; key_in = '0; key_valid = 1'b0; replay = 1'b0; rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_zero_key();
    test_backpressure();
    test_replay_hold();
    test_replay_serve();
    test_key_abort();
    test_rst_mid_expand();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_round_key_server.md
Name: inv_round_key_server

Overview:
- Consumer-side counterpart of the team's forward AES-128 key schedule.
- Accepts a 128-bit cipher key and expands it iteratively, one round per cycle, into an 11-entry round-key store.
- Streams the round keys in reverse order (round 10 down to round 0) to the decryption datapath over a valid/ready handshake.
- Supports replay of the reverse stream without re-expansion.

Parameters:
- NR, 10, number of rounds; the store holds NR+1 round keys.
- KEY_W, 128, round-key width in bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- key_in  in  128  cipher key; word k = bits [32k+31:32k]
- key_valid  in  1  key_in offered
- key_ready  out  1  key can be accepted
- replay  in  1  single-cycle request to restart the reverse stream at round NR
- rk_out  out  128  round key being presented
- rk_round  out  4  round index of rk_out
- rk_valid  out  1  rk_out valid
- rk_ready  in  1  consumer accepts rk_out
- rk_last  out  1  rk_valid and rk_round==0
- busy  out  1  high in EXPAND

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Forward step, for round i = 1..NR, from previous key P0..P3 to new key W0..W3:
  - g(x,i) = {x[23:0],x[31:24]} ^ {rcon(i),24'h0}.
  - rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36.
  - There is no SubWord stage, matching the team schedule exactly.
  - W0 = P0 ^ g(P0,i); W1 = P1 ^ W0; W2 = P2 ^ W1; W3 = P3 ^ W2.
- States:
  - IDLE: key_ready=1, rk_valid=0. A key handshake stores the key as rk[0], sets cnt=1, and moves to EXPAND.
  - EXPAND: key_ready=0, busy=1. Each cycle writes rk[cnt] = step(rk[cnt-1], cnt) and increments cnt. The cycle that writes rk[NR] moves to SERVE with idx=NR.
  - SERVE: rk_valid=1, rk_out=rk[idx], rk_round=idx, key_ready=1.
    - On rk_valid&rk_ready with idx>0: idx decrements.
    - With idx==0: moves to HOLD.
  - HOLD: rk_valid=0, key_ready=1, store retained. replay moves to SERVE with idx=NR.
- Latency:
  - Key accepted at edge T; rk_valid first high in the cycle after edge T+NR (11 cycles).
  - After that, sustained 1 key per cycle while rk_ready=1.
- Handshake:
  - rk_out and rk_round are held stable while rk_valid&!rk_ready.
  - rk_valid never drops without a handshake, except on a new key or on rst.
- Replay:
  - In SERVE, idx is set to NR next cycle; a same-cycle rk handshake is consumed but does not decrement.
  - Ignored in IDLE and EXPAND.
- Simultaneous events:
  - key_valid and replay in the same cycle: the key wins.
  - A key accepted in SERVE aborts the stream. rk_valid=0 next cycle and expansion restarts.
  - key_valid during EXPAND is not accepted, because key_ready=0.
- Reset values (any state, including mid-EXPAND or mid-stream): IDLE, key_ready=1, rk_valid=0, rk_last=0, busy=0, rk_out=0, rk_round=0, cnt=0, idx=0. Store contents are don't-care.
- Width rules: cnt and idx are 4 bits. rcon is a combinational lookup on cnt; cnt values outside 1..10 give rcon 0 and do not occur in operation.

Decomposition:
- Package inv_key_pkg holds:
  - NR and KEY_W constants;
  - the rcon lookup function;
  - the state enum (IDLE, EXPAND, SERVE, HOLD);
  - a round_key_t 128-bit typedef.
- Sub-module key_round_step is a combinational single forward round: inputs prev key and round index, output next key. It is instanced once and reused each EXPAND cycle.
- The store is an 11 x 128 register array.

Test Plan:
- Zero key, rk_ready=1 -> rk_valid rises 11 cycles after accept, then 11 keys in this order:
  - round 10 first;
  - round 2 = 02000001_03000001_02000001_03000001 (W3..W0);
  - round 1 = 01000000_01000000_01000000_01000000;
  - round 0 = 0 with rk_last=1;
  - then HOLD with rk_valid=0.
- Backpressure: rk_ready toggles 1,0,0,1 per cycle -> rk_out/rk_round stable through stalls; no key dropped or duplicated; rk_round sequence strictly 10..0.
- Replay:
  - in HOLD: pulse -> round 10 is presented the next cycle and the full stream repeats with no busy assertion;
  - in SERVE at idx=4: pulse -> next presented round is 10.
- Key accepted in SERVE with a concurrent replay pulse at idx=6 -> key wins; rk_valid=0 next cycle; busy for 10 cycles; the new stream starts at round 10 of the new key.
- rst asserted mid-EXPAND (cnt=5) -> next cycle IDLE, busy=0, rk_valid=0, key_ready=1; a subsequent key expands correctly.
- Random keys vs reference model of the forward step -> all 11 round keys match, in reverse order.
